alu_stream: RTL and testbench
=============================

Name: alu_stream

Overview:
- Parametrised successor to the 32-bit combinational ALU32bit, same 4-bit sel encoding, extended opcode set.
- Registered, valid/ready-handshaked ALU sitting between the decode/operand-fetch stage and writeback.
- Single-cycle ops stream at one result per cycle; optional iterative multiply/divide ops stall input for a fixed WIDTH+1 cycles.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of in-flight op and output register.
- in_valid  in  1  operands/sel valid.
- in_ready  out  1  block accepts this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  4  opcode.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- illegal  out  1  registered; op was unsupported.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, result=0, zero=0, illegal=0, FSM=IDLE, iteration counter=0. in_ready is combinational and reads 1 out of reset.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB.
  - 0100 SLL, 0101 SRL, 1000 SRA; shift amount = b[SHW-1:0].
  - 0111 SLT (signed), 1001 SLTU; result is 0 or 1, zero-extended.
  - 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned).
  - 1100 DIVU, 1101 REMU.
  - 1110/1111 illegal.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Accept occurs when in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops:
  - Latency 1: out_valid, result, zero and illegal are updated at the accept edge.
  - Back-to-back accepts give one result per cycle.
- FSM states:
  - IDLE: a muldiv accept goes to CALC; capture operands, counter=0.
  - CALC: one bit per cycle (shift-add multiply / restoring divide); counter increments each cycle. When counter==WIDTH-1, go to IDLE and load the output register with out_valid=1.
  - Result appears WIDTH edges after the accept edge (WIDTH+1 cycles including accept); in_ready=0 throughout CALC.
- Output hold: while out_valid && !out_ready, result/zero/illegal are stable and in_ready=0.
- out_valid clears on an out_ready edge unless a new accept occurs on the same edge, in which case the register reloads.
- Divide by zero: DIVU gives all-ones, REMU gives a. No exception.
- flush (synchronous, highest priority after reset):
  - Next edge: FSM=IDLE, out_valid=0, counter=0.
  - Any accept on the same edge is discarded.
- Reset asserted mid-CALC: immediate return to reset values; the partial result is lost.
- illegal: 1 for opcodes 1110/1111 (and muldiv when disabled). Then result=0, zero=1, latency 1.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: opcodes 1010–1101 execute via the iterative unit as above.
- Undefined: no iterative unit or CALC state is synthesised. Opcodes 1010–1101 behave as illegal (latency 1, result=0, zero=1, illegal=1).

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_AND … OP_REMU) and their 4-bit type;
  - FSM state enum (IDLE, CALC);
  - function is_muldiv(sel).
- One sub-module: alu_muldiv_iter. It holds the operand registers, counter, shift-add/restoring-divide datapath and a done pulse; it is instantiated only under ALU_MULDIV_EN.

Test Plan (WIDTH=32):
- Basic ADD: release rst_n, send ADD a=2 b=2 -> next edge out_valid=1, result=4, zero=0, illegal=0.
- Streaming: out_ready=1, send AND 0xA,0x5 / OR 100,55 / SUB 100,55 on consecutive cycles -> results 0 (zero=1), 119, 45 on consecutive cycles, in order.
- Backpressure: out_ready=0 after OR 10,5 -> result=15 held and in_ready=0 for 5 cycles; out_ready=1 -> pending SRA 0x80000000,4 accepted, result 0xF8000000.
- Multiply: MUL / MULHU on 0xFFFFFFFF × 0xFFFFFFFF -> 1 and 0xFFFFFFFE, each 32 edges after accept; in_ready=0 during CALC.
- Divide: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 10/0 -> 0xFFFFFFFF; REMU 10/0 -> 10.
- Abort and disabled-feature cases:
  - rst_n low at CALC cycle 10 -> out_valid=0 immediately, no late result.
  - flush at CALC cycle 10 -> same outcome after one edge.
  - Macro undefined: MUL -> illegal=1, result=0, latency 1; sel=1111 -> illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and helpers for the streaming ALU.
package alu_pkg;

   typedef logic [3:0] opcode_t;

   localparam opcode_t OP_AND   = 4'b0000;
   localparam opcode_t OP_OR    = 4'b0001;
   localparam opcode_t OP_ADD   = 4'b0010;
   localparam opcode_t OP_XOR   = 4'b0011;
   localparam opcode_t OP_SLL   = 4'b0100;
   localparam opcode_t OP_SRL   = 4'b0101;
   localparam opcode_t OP_SUB   = 4'b0110;
   localparam opcode_t OP_SLT   = 4'b0111;
   localparam opcode_t OP_SRA   = 4'b1000;
   localparam opcode_t OP_SLTU  = 4'b1001;
   localparam opcode_t OP_MUL   = 4'b1010;
   localparam opcode_t OP_MULHU = 4'b1011;
   localparam opcode_t OP_DIVU  = 4'b1100;
   localparam opcode_t OP_REMU  = 4'b1101;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   function automatic logic is_muldiv(input opcode_t op);
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply (shift-add) and divide (restoring) unit; one bit per cycle,
// WIDTH cycles per op. Only instantiated when ALU_MULDIV_EN is defined.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             start,
   input  logic             calc,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   // hi/lo hold {product high, multiplier/product low} or {remainder, dividend/quotient}
   logic [WIDTH-1:0] hi_q, lo_q, opb_q;
   logic [3:0]       op_q;
   logic [SHW-1:0]   cnt_q;

   logic             is_mul;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH+1:0] div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] div_hi_n, div_lo_n;
   logic [WIDTH-1:0] hi_n, lo_n;

   always_comb begin
      is_mul   = (op_q == OP_MUL) || (op_q == OP_MULHU);
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      mul_hi_n = mul_sum[WIDTH:1];
      mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
      // A zero divisor always "fits", which yields all-ones quotient and remainder == a.
      div_sh   = {hi_q, lo_q[WIDTH-1]};
      div_diff = {1'b0, div_sh} - {2'b00, opb_q};
      div_ge   = !div_diff[WIDTH+1];
      div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      div_lo_n = {lo_q[WIDTH-2:0], div_ge};
      hi_n     = is_mul ? mul_hi_n : div_hi_n;
      lo_n     = is_mul ? mul_lo_n : div_lo_n;
      case (op_q)
         OP_MUL:  result = lo_n;
         OP_MULHU: result = hi_n;
         OP_DIVU: result = lo_n;
         default: result = hi_n;
      endcase
   end

   assign done = calc && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         opb_q <= '0;
         op_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else if (start) begin
         op_q  <= op;
         hi_q  <= '0;
         cnt_q <= '0;
         if ((op == OP_MUL) || (op == OP_MULHU)) begin
            lo_q  <= b;
            opb_q <= a;
         end else begin
            lo_q  <= a;
            opb_q <= b;
         end
      end else if (calc) begin
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         cnt_q <= done ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_stream.sv
// Registered, valid/ready-handshaked ALU between operand fetch and writeback.
// Define ALU_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU unit.
module alu_stream
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int SHW = $clog2(WIDTH);

   // Handshake: a transfer happens on a rising edge where valid && ready; the
   // producer holds data stable while valid && !ready, ready never waits on valid.
   state_t           state_q, state_d;
   logic             accept;
   logic             md_start, md_done;
   logic [WIDTH-1:0] md_result;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;
   logic [SHW-1:0]   shamt;

   assign shamt = b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (sel)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_ADD:  alu_res = a + b;
         OP_XOR:  alu_res = a ^ b;
         OP_SUB:  alu_res = a - b;
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $signed(a) >>> shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         // muldiv opcodes land here too; with the unit present they never load from this path
         default: alu_ill = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_EN
   assign md_start = accept && is_muldiv(sel);

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .start  (md_start),
      .calc   (state_q == CALC),
      .op     (sel),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .result (md_result)
   );
`else
   assign md_start  = 1'b0;
   assign md_done   = 1'b0;
   assign md_result = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (md_start) state_d = CALC;
         CALC:    if (md_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_comb begin
      in_ready = (state_q == IDLE) && (!out_valid || out_ready);
      accept   = in_valid && in_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (md_done) begin
         out_valid <= 1'b1;
         result    <= md_result;
         zero      <= (md_result == '0);
         illegal   <= 1'b0;
      end else if (accept && !md_start) begin
         out_valid <= 1'b1;
         result    <= alu_res;
         zero      <= (alu_res == '0);
         illegal   <= alu_ill;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_stream.sv
// Directed and randomized checks of alu_stream (WIDTH=32) against a behavioural model.
// Exercises the iterative path when ALU_MULDIV_EN is defined.
module tb_alu_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  sel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int compared = 0;
   int mismatched = 0;
   logic [32:0] exp_q[$];

   alu_stream #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: returns {illegal, result} from the opcode table using plain arithmetic.
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      int unsigned s;
      s = y % 32;
      p = 64'(x) * 64'(y);
      case (op)
         4'd0:  return {1'b0, x & y};
         4'd1:  return {1'b0, x | y};
         4'd2:  return {1'b0, x + y};
         4'd3:  return {1'b0, x ^ y};
         4'd4:  return {1'b0, x << s};
         4'd5:  return {1'b0, x >> s};
         4'd6:  return {1'b0, x - y};
         4'd7:  return {1'b0, 32'(((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 1 : 0)};
         4'd8:  return {1'b0, (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0)};
         4'd9:  return {1'b0, 32'((x < y) ? 1 : 0)};
`ifdef ALU_MULDIV_EN
         4'd10: return {1'b0, p[31:0]};
         4'd11: return {1'b0, p[63:32]};
         4'd12: return {1'b0, (y == 0) ? 32'hFFFF_FFFF : x / y};
         4'd13: return {1'b0, (y == 0) ? x : x % y};
`endif
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      sel = op;
      a = x;
      b = y;
      in_valid = 1'b1;
   endtask

   // Compares the output register against the model for op/x/y.
   task automatic check_out(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [32:0] e;
      e = ref_alu(op, x, y);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_result"}, result, e[31:0]);
      check({tag, "_illegal"}, illegal, e[32]);
      check({tag, "_zero"}, zero, e[31:0] == 32'h0);
   endtask

`ifdef ALU_MULDIV_EN
   task automatic muldiv_op(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      out_ready = 1'b1;
      drive(op, x, y);
      #1;
      check({tag, "_accept_ready"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check({tag, "_busy"}, {out_valid, in_ready}, 2'b00);
         tick();
      end
      check_out(tag, op, x, y);
   endtask
`endif

   initial begin
      logic [3:0]  r_op;
      logic [31:0] r_a, r_b;
      logic        acc;

      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      sel = 4'h0;
      a = '0;
      b = '0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, 32'h0);
      check("rst_zero", zero, 1'b0);
      check("rst_illegal", illegal, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      tick();
      tick();
      rst_n = 1'b1;

      // Basic ADD, latency 1
      out_ready = 1'b1;
      drive(4'b0010, 32'd2, 32'd2);
      tick();
      check("add_valid", out_valid, 1'b1);
      check("add_result", result, 32'd4);
      check("add_zero", zero, 1'b0);
      check("add_illegal", illegal, 1'b0);

      // Streaming: one result per cycle, in order
      drive(4'b0000, 32'hA, 32'h5);
      tick();
      check("and_result", result, 32'd0);
      check("and_zero", zero, 1'b1);
      drive(4'b0001, 32'd100, 32'd55);
      tick();
      check("or_result", result, 32'd119);
      drive(4'b0110, 32'd100, 32'd55);
      tick();
      check("sub_result", result, 32'd45);
      check("sub_valid", out_valid, 1'b1);

      // Backpressure hold, then pending SRA is taken
      drive(4'b0001, 32'd10, 32'd5);
      tick();
      check("bp_or_result", result, 32'd15);
      out_ready = 1'b0;
      drive(4'b1000, 32'h8000_0000, 32'd4);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_hold", {out_valid, result}, {1'b1, 32'd15});
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      check("bp_sra_result", result, 32'hF800_0000);
      check_out("bp_sra", 4'b1000, 32'h8000_0000, 32'd4);

      // Illegal opcode
      drive(4'b1111, 32'd7, 32'd9);
      tick();
      in_valid = 1'b0;
      check("ill_1111", {illegal, zero, result}, {1'b1, 1'b1, 32'h0});
      drive(4'b1110, 32'd1, 32'd1);
      tick();
      in_valid = 1'b0;
      check_out("ill_1110", 4'b1110, 32'd1, 32'd1);

`ifdef ALU_MULDIV_EN
      muldiv_op("mul_ones", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mul_ones_lit", result, 32'd1);
      muldiv_op("mulhu_ones", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mulhu_ones_lit", result, 32'hFFFF_FFFE);
      muldiv_op("divu_100_7", 4'b1100, 32'd100, 32'd7);
      check("divu_lit", result, 32'd14);
      muldiv_op("remu_100_7", 4'b1101, 32'd100, 32'd7);
      check("remu_lit", result, 32'd2);
      muldiv_op("divu_by0", 4'b1100, 32'd10, 32'd0);
      check("divu_by0_lit", result, 32'hFFFF_FFFF);
      muldiv_op("remu_by0", 4'b1101, 32'd10, 32'd0);
      check("remu_by0_lit", result, 32'd10);
      for (int i = 0; i < 4; i++) begin
         r_op = 4'(10 + i);
         r_a = $urandom;
         r_b = (i >= 2) ? 32'($urandom_range(1, 5000)) : $urandom;
         muldiv_op("muldiv_rnd", r_op, r_a, r_b);
      end

      // Reset during CALC
      out_ready = 1'b1;
      drive(4'b1010, 32'd123, 32'd456);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      #1;
      check("rstabort_valid", out_valid, 1'b0);
      check("rstabort_ready", in_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         check("rstabort_no_late", out_valid, 1'b0);
         tick();
      end

      // Flush during CALC
      drive(4'b1100, 32'd1000, 32'd3);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flushabort_valid", out_valid, 1'b0);
      check("flushabort_ready", in_ready, 1'b1);
      for (int i = 0; i < 40; i++) begin
         check("flushabort_no_late", out_valid, 1'b0);
         tick();
      end
`else
      // Disabled iterative unit: muldiv opcodes are illegal with latency 1
      drive(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      in_valid = 1'b0;
      check("mul_dis", {out_valid, illegal, zero, result}, {3'b111, 32'h0});
      drive(4'b1101, 32'd100, 32'd7);
      tick();
      in_valid = 1'b0;
      check_out("remu_dis", 4'b1101, 32'd100, 32'd7);
`endif

      // Flush discards a same-edge accept
      out_ready = 1'b1;
      drive(4'b0010, 32'd5, 32'd6);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_discard", out_valid, 1'b0);

      // Randomized stream with random backpressure
      tick();
      for (int i = 0; i < 200; i++) begin
         r_op = 4'($urandom_range(0, 15));
`ifdef ALU_MULDIV_EN
         if (r_op >= 4'd10 && r_op <= 4'd13) r_op = 4'b0010;
`endif
         r_a = $urandom;
         r_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         sel = r_op;
         a = r_a;
         b = r_b;
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         acc = in_valid && (exp_q.size() == 0 || out_ready);
         check("rnd_in_ready", in_ready, (exp_q.size() == 0) || out_ready);
         tick();
         if (acc) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_q.push_back(ref_alu(r_op, r_a, r_b));
         end else if (out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
         end
         check("rnd_valid", out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            check("rnd_out", {illegal, result}, exp_q[0]);
            check("rnd_zero", zero, exp_q[0][31:0] == 32'h0);
         end
      end
      in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
